// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_pkg
// Purpose  : Shared definitions for the register_bank_nx datapath register file.
//            - The FunSel operation codes. Their encoding matches the original
//              single 32-bit register exactly.
//            - A helper that returns the number of bytes in a register word.
// Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;  // Q - 1
  localparam logic [2:0] FS_INC  = 3'b001;  // Q + 1
  localparam logic [2:0] FS_LOAD = 3'b010;  // Q <= I
  localparam logic [2:0] FS_CLR  = 3'b011;  // Q <= 0
  localparam logic [2:0] FS_LDB0 = 3'b100;  // zero-extend I[7:0]
  localparam logic [2:0] FS_LDH0 = 3'b101;  // zero-extend I[15:0]
  localparam logic [2:0] FS_SHB  = 3'b110;  // shift left one byte, I[7:0] enters at the bottom
  localparam logic [2:0] FS_LDHS = 3'b111;  // sign-extend I[15:0]

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : reg_slice
// Purpose  : One register of the bank. It holds the register value, the sticky
//            wrap flag, the byte-assembly counter and the ByteFull flag.
// Ports    : Clock      - system clock, rising edge
//            Reset_n    - asynchronous active-low reset
//            en         - write enable for this register
//            fun_sel    - operation code (see regbank_pkg)
//            din        - shared data input
//            q          - register value
//            wrap       - sticky wrap / saturation flag
//            byte_full  - high once WIDTH/8 bytes have been shifted in
// Config   : REGBANK_SATURATE_EN - when defined, inc/dec saturate instead of
//            wrapping. The wrap flag is still set in those cases.
// Revision : 1.0 - initial release
// ============================================================================
module reg_slice
  import regbank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             en,
  input  logic [2:0]       fun_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             byte_full
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int CNT_W = $clog2(BPW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPW);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             all_ones;
  logic             is_zero;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  assign all_ones = &q;
  assign is_zero  = ~|q;
  // Saturating byte counter: a shift while already full keeps the count at the maximum.
  assign cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

`ifdef REGBANK_SATURATE_EN
  assign inc_val = all_ones ? q : q + WIDTH'(1);
  assign dec_val = is_zero  ? q : q - WIDTH'(1);
`else
  assign inc_val = q + WIDTH'(1);
  assign dec_val = q - WIDTH'(1);
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      q         <= '0;
      wrap      <= 1'b0;
      cnt       <= '0;
      byte_full <= 1'b0;
    end else if (en) begin
      // Every operation except the byte shift restarts byte assembly.
      cnt       <= '0;
      byte_full <= 1'b0;
      case (fun_sel)
        FS_DEC: begin
          q <= dec_val;
          if (is_zero) wrap <= 1'b1;
        end
        FS_INC: begin
          q <= inc_val;
          if (all_ones) wrap <= 1'b1;
        end
        FS_LOAD: begin
          q    <= din;
          wrap <= 1'b0;
        end
        FS_CLR: begin
          q    <= '0;
          wrap <= 1'b0;
        end
        FS_LDB0: begin
          q    <= WIDTH'(din[7:0]);
          wrap <= 1'b0;
        end
        // For a 16-bit register, both half-word loads reduce to a plain load.
        FS_LDH0: begin
          q    <= WIDTH'(din[15:0]);
          wrap <= 1'b0;
        end
        FS_SHB: begin
          q         <= {q[WIDTH-9:0], din[7:0]};
          cnt       <= cnt_inc;
          byte_full <= (cnt_inc == CNT_MAX);
        end
        FS_LDHS: begin
          q    <= WIDTH'($signed(din[15:0]));
          wrap <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_bank_nx.sv
`default_nettype none
// ============================================================================
// Module   : register_bank_nx
// Purpose  : Bank of NUM_REGS WIDTH-bit datapath registers. Each register has
//            its own enable, and all registers share one FunSel code. The bank
//            has two combinational read ports that feed the ALU operand muxes.
// Ports    : Clock, Reset_n   - clock (rising edge), asynchronous active-low reset
//            E                - per-register write enable
//            FunSel           - operation applied to every enabled register
//            I                - shared data input
//            OutASel/OutBSel  - read selects; selects >= NUM_REGS read as 0
//            OutA/OutB        - read data; shows the value from before the edge
//            Wrap             - sticky per-register wrap flags
//            ByteFull         - per-register byte-assembly-complete flags
// Config   : REGBANK_SATURATE_EN - when defined, inc/dec saturate (see reg_slice).
// Revision : 1.0 - initial release
// ============================================================================
module register_bank_nx
  import regbank_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NUM_REGS-1:0] E,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Wrap,
  output logic [NUM_REGS-1:0] ByteFull
);

  localparam int SLOTS = 1 << SEL_W;

  // The read array is padded to a power of two. Any select that is out of
  // range then lands on a zero slot, so no range comparison is needed.
  logic [WIDTH-1:0] regs [SLOTS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_slice
    reg_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .en        (E[r]),
      .fun_sel   (FunSel),
      .din       (I),
      .q         (regs[r]),
      .wrap      (Wrap[r]),
      .byte_full (ByteFull[r])
    );
  end

  for (genvar p = NUM_REGS; p < SLOTS; p++) begin : g_pad
    assign regs[p] = '0;
  end

  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule
`default_nettype wire

// File: tb/tb_register_bank_nx.sv
`timescale 1ns/100ps
module tb_register_bank_nx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT 0: default 32 x 4
  logic [3:0]  e0;  logic [2:0] fs0; logic [31:0] i0; logic [1:0] a0, b0;
  logic [31:0] oa0, ob0; logic [3:0] wr0, bf0;
  // DUT 1: 16 x 8
  logic [7:0]  e1;  logic [2:0] fs1; logic [15:0] i1; logic [2:0] a1, b1;
  logic [15:0] oa1, ob1; logic [7:0] wr1, bf1;
  // DUT 2: 24 x 3 (non-power-of-two count, so one select is out of range)
  logic [2:0]  e2;  logic [2:0] fs2; logic [23:0] i2; logic [1:0] a2, b2;
  logic [23:0] oa2, ob2; logic [2:0] wr2, bf2;

  register_bank_nx #(.WIDTH(32), .NUM_REGS(4)) dut0 (
    .Clock(clk), .Reset_n(rst_n), .E(e0), .FunSel(fs0), .I(i0),
    .OutASel(a0), .OutBSel(b0), .OutA(oa0), .OutB(ob0), .Wrap(wr0), .ByteFull(bf0));
  register_bank_nx #(.WIDTH(16), .NUM_REGS(8)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .E(e1), .FunSel(fs1), .I(i1),
    .OutASel(a1), .OutBSel(b1), .OutA(oa1), .OutB(ob1), .Wrap(wr1), .ByteFull(bf1));
  register_bank_nx #(.WIDTH(24), .NUM_REGS(3)) dut2 (
    .Clock(clk), .Reset_n(rst_n), .E(e2), .FunSel(fs2), .I(i2),
    .OutASel(a2), .OutBSel(b2), .OutA(oa2), .OutB(ob2), .Wrap(wr2), .ByteFull(bf2));

  int W[3]  = '{32, 16, 24};
  int N[3]  = '{4, 8, 3};
  int SW[3] = '{2, 3, 2};

  // Reference model: value, wrap flag and shifted-byte count per register.
  longint mq[3][8];
  bit     mw[3][8];
  int     mc[3][8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 8; r++) begin
        mq[d][r] = 0; mw[d][r] = 0; mc[d][r] = 0;
      end
  endtask

  task automatic model_op(input int d, input int r, input logic [2:0] fs, input logic [31:0] din);
    longint mask = (longint'(1) << W[d]) - 1;
    int     bpw  = W[d] / 8;
    longint q    = mq[d][r];
    longint dv   = {32'd0, din};
    if (fs != 3'b110) mc[d][r] = 0;
    case (fs)
      3'b000: begin
        if (q == 0) begin
          mw[d][r] = 1;
`ifdef REGBANK_SATURATE_EN
          q = 0;
`else
          q = mask;
`endif
        end else q = q - 1;
      end
      3'b001: begin
        if (q == mask) begin
          mw[d][r] = 1;
`ifdef REGBANK_SATURATE_EN
          q = mask;
`else
          q = 0;
`endif
        end else q = q + 1;
      end
      3'b010: begin q = dv & mask; mw[d][r] = 0; end
      3'b011: begin q = 0; mw[d][r] = 0; end
      3'b100: begin q = dv & 64'hFF; mw[d][r] = 0; end
      3'b101: begin q = (W[d] == 16) ? (dv & mask) : (dv & 64'hFFFF); mw[d][r] = 0; end
      3'b110: begin
        q = ((q << 8) | (dv & 64'hFF)) & mask;
        if (mc[d][r] < bpw) mc[d][r]++;
      end
      default: begin
        if (W[d] == 16) q = dv & mask;
        else if (din[15]) q = (mask & ~64'hFFFF) | (dv & 64'hFFFF);
        else q = dv & 64'hFFFF;
        mw[d][r] = 0;
      end
    endcase
    mq[d][r] = q;
  endtask

  task automatic set_in(input int d, input logic [7:0] e, input logic [2:0] fs, input logic [31:0] din);
    case (d)
      0: begin e0 = e[3:0]; fs0 = fs; i0 = din; end
      1: begin e1 = e;      fs1 = fs; i1 = din[15:0]; end
      default: begin e2 = e[2:0]; fs2 = fs; i2 = din[23:0]; end
    endcase
  endtask

  task automatic set_sel(input int d, input int a, input int b);
    case (d)
      0: begin a0 = a[1:0]; b0 = b[1:0]; end
      1: begin a1 = a[2:0]; b1 = b[2:0]; end
      default: begin a2 = a[1:0]; b2 = b[1:0]; end
    endcase
  endtask

  function automatic logic [31:0] get_oa(input int d);
    case (d)
      0: return oa0;
      1: return {16'd0, oa1};
      default: return {8'd0, oa2};
    endcase
  endfunction

  function automatic logic [31:0] get_ob(input int d);
    case (d)
      0: return ob0;
      1: return {16'd0, ob1};
      default: return {8'd0, ob2};
    endcase
  endfunction

  function automatic logic [7:0] get_wr(input int d);
    case (d)
      0: return {4'd0, wr0};
      1: return wr1;
      default: return {5'd0, wr2};
    endcase
  endfunction

  function automatic logic [7:0] get_bf(input int d);
    case (d)
      0: return {4'd0, bf0};
      1: return bf1;
      default: return {5'd0, bf2};
    endcase
  endfunction

  // Apply one operation on one edge, advance the model, then idle the enables.
  task automatic do_op(input int d, input logic [7:0] e, input logic [2:0] fs, input logic [31:0] din);
    set_in(d, e, fs, din);
    @(posedge clk);
    for (int r = 0; r < N[d]; r++)
      if (e[r]) model_op(d, r, fs, din);
    #1;
    set_in(d, 8'd0, fs, din);
  endtask

  // Sweep every select value on both ports and compare all flags with the model.
  task automatic check_dut(input int d, input string tag);
    logic [31:0] ea, eb;
    logic [7:0]  ew, ef;
    int slots = 1 << SW[d];
    for (int k = 0; k < slots; k++) begin
      set_sel(d, k, slots - 1 - k);
      #1;
      ea = (k < N[d]) ? mq[d][k][31:0] : 32'd0;
      eb = (slots - 1 - k < N[d]) ? mq[d][slots-1-k][31:0] : 32'd0;
      n_checks++;
      if (get_oa(d) !== ea) begin
        n_fail++;
        $display("FAIL %s dut%0d OutA sel=%0d got %h expected %h", tag, d, k, get_oa(d), ea);
      end
      n_checks++;
      if (get_ob(d) !== eb) begin
        n_fail++;
        $display("FAIL %s dut%0d OutB sel=%0d got %h expected %h", tag, d, slots-1-k, get_ob(d), eb);
      end
    end
    ew = '0; ef = '0;
    for (int r = 0; r < N[d]; r++) begin
      ew[r] = mw[d][r];
      ef[r] = (mc[d][r] == W[d] / 8);
    end
    n_checks++;
    if (get_wr(d) !== ew) begin
      n_fail++;
      $display("FAIL %s dut%0d Wrap got %b expected %b", tag, d, get_wr(d), ew);
    end
    n_checks++;
    if (get_bf(d) !== ef) begin
      n_fail++;
      $display("FAIL %s dut%0d ByteFull got %b expected %b", tag, d, get_bf(d), ef);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    for (int d = 0; d < 3; d++) check_dut(d, "reset");
    @(negedge clk); rst_n = 1'b1;
    // Build R0 = 1234_5678 with Wrap[0]=1 and ByteFull[0]=1
    do_op(0, 8'h1, 3'b011, 32'd0);
    do_op(0, 8'h1, 3'b000, 32'd0);
    do_op(0, 8'h1, 3'b110, 32'h12);
    do_op(0, 8'h1, 3'b110, 32'h34);
    do_op(0, 8'h1, 3'b110, 32'h56);
    do_op(0, 8'h1, 3'b110, 32'h78);
    check_dut(0, "preload");
    set_sel(0, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (oa0 !== 32'd0 || wr0 !== 4'd0 || bf0 !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset R0=%h Wrap=%b ByteFull=%b expected all zero", oa0, wr0, bf0);
    end
    check_dut(0, "reset_held");
    @(negedge clk); rst_n = 1'b1;
    do_op(0, 8'h1, 3'b110, 32'hAB);
    do_op(0, 8'h1, 3'b110, 32'hCD);
    check_dut(0, "shift_restart");
  endtask

  task automatic test_inc_wrap();
    do_op(0, 8'hD, 3'b010, 32'h0BAD_F00D);
    do_op(0, 8'h2, 3'b010, 32'hFFFF_FFFF);
    do_op(0, 8'h2, 3'b001, $urandom);
    set_sel(0, 1, 0);
    #1;
    n_checks++;
`ifdef REGBANK_SATURATE_EN
    if (oa0 !== 32'hFFFF_FFFF) begin
`else
    if (oa0 !== 32'h0000_0000) begin
`endif
      n_fail++;
      $display("FAIL inc_wrap R1 got %h", oa0);
    end
    n_checks++;
    if (wr0 !== 4'b0010 || ob0 !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL inc_wrap Wrap got %b expected 0010, R0 got %h expected 0badf00d", wr0, ob0);
    end
    check_dut(0, "inc_wrap");
  endtask

  task automatic test_shift();
    logic [7:0] bytes [5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    for (int k = 0; k < 5; k++) begin
      do_op(0, 8'h4, 3'b110, {24'd0, bytes[k]});
      set_sel(0, 2, 2);
      #1;
      n_checks++;
      if (bf0[2] !== (k >= 3)) begin
        n_fail++;
        $display("FAIL shift ByteFull[2] after byte %0d got %b", k + 1, bf0[2]);
      end
      if (k == 3) begin
        n_checks++;
        if (oa0 !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL shift R2 got %h expected deadbeef", oa0);
        end
      end
    end
    n_checks++;
    if (oa0 !== 32'hADBE_EF01) begin
      n_fail++;
      $display("FAIL shift5 R2 got %h expected adbeef01", oa0);
    end
    do_op(0, 8'h4, 3'b011, 32'd0);
    #1;
    n_checks++;
    if (oa0 !== 32'd0 || bf0[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_clr R2 got %h ByteFull[2] got %b expected 0/0", oa0, bf0[2]);
    end
    check_dut(0, "shift");
  endtask

  task automatic test_extend();
    logic [2:0]  codes [3] = '{3'b111, 3'b101, 3'b100};
    logic [31:0] exps  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0001};
    for (int k = 0; k < 3; k++) begin
      do_op(0, 8'h8, codes[k], 32'h5A5A_8001);
      set_sel(0, 3, 3);
      #1;
      n_checks++;
      if (oa0 !== exps[k]) begin
        n_fail++;
        $display("FAIL extend code %b R3 got %h expected %h", codes[k], oa0, exps[k]);
      end
    end
    check_dut(0, "extend");
  endtask

  task automatic test_dec_all();
    @(negedge clk); rst_n = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    set_in(0, 8'hF, 3'b000, 32'd0);
    set_sel(0, 0, 3);
    #1;
    n_checks++;
    if (oa0 !== 32'd0) begin
      n_fail++;
      $display("FAIL pre_edge OutA got %h expected 00000000", oa0);
    end
    @(posedge clk);
    for (int r = 0; r < 4; r++) model_op(0, r, 3'b000, 32'd0);
    #1;
    set_in(0, 8'd0, 3'b000, 32'd0);
    n_checks++;
`ifdef REGBANK_SATURATE_EN
    if (oa0 !== 32'd0 || wr0 !== 4'hF) begin
`else
    if (oa0 !== 32'hFFFF_FFFF || wr0 !== 4'hF) begin
`endif
      n_fail++;
      $display("FAIL dec_all R0 got %h Wrap got %b", oa0, wr0);
    end
    check_dut(0, "dec_all");
  endtask

  task automatic test_w16();
    logic [15:0] v;
    for (int k = 0; k < 2; k++) begin
      v = 16'($urandom);
      do_op(1, 8'h20, 3'b011, 32'd0);
      do_op(1, 8'h20, (k == 0) ? 3'b101 : 3'b111, {16'hFFFF, v});
      set_sel(1, 5, 5);
      #1;
      n_checks++;
      if (oa1 !== v) begin
        n_fail++;
        $display("FAIL w16 code %0d R5 got %h expected %h", k, oa1, v);
      end
    end
    do_op(1, 8'h40, 3'b110, 32'h12);
    #1;
    n_checks++;
    if (bf1[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL w16 ByteFull[6] after 1 byte got %b expected 0", bf1[6]);
    end
    do_op(1, 8'h40, 3'b110, 32'h34);
    set_sel(1, 6, 6);
    #1;
    n_checks++;
    if (bf1[6] !== 1'b1 || oa1 !== 16'h1234) begin
      n_fail++;
      $display("FAIL w16 shift R6 got %h ByteFull %b expected 1234/1", oa1, bf1[6]);
    end
    check_dut(1, "w16");
  endtask

  task automatic test_random();
    int d;
    logic [31:0] din;
    for (int it = 0; it < 150; it++) begin
      d = $urandom_range(0, 2);
      din = $urandom;
      if ($urandom_range(0, 7) == 0) din = 32'hFFFF_FFFF;
      do_op(d, 8'($urandom) & 8'((1 << N[d]) - 1), 3'($urandom_range(0, 7)), din);
      check_dut(d, "random");
    end
  endtask

  initial begin
    e0 = '0; fs0 = '0; i0 = '0; a0 = '0; b0 = '0;
    e1 = '0; fs1 = '0; i1 = '0; a1 = '0; b1 = '0;
    e2 = '0; fs2 = '0; i2 = '0; a2 = '0; b2 = '0;
    test_reset();
    test_inc_wrap();
    test_shift();
    test_extend();
    test_dec_all();
    test_w16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
